// File: rtl/lvds_serializer_if.sv
// System-to-serial boundary: four-phase word handshake plus the serial output lanes.
interface lvds_serializer_if #(
   parameter int PARALLEL_WIDTH = 8
);
   logic [PARALLEL_WIDTH-1:0] tx_parallel_word;
   logic                      tx_word_valid;
   logic                      ack_serial;
   logic                      serial_out;
   logic                      serial_frame;
   logic                      serial_data_valid;
   logic                      underrun;

   modport master (
      output tx_parallel_word, tx_word_valid,
      input  ack_serial, serial_out, serial_frame, serial_data_valid, underrun
   );

   modport slave (
      input  tx_parallel_word, tx_word_valid,
      output ack_serial, serial_out, serial_frame, serial_data_valid, underrun
   );
endinterface

// File: rtl/lvds_serializer.sv
// Double-buffered MSB-first serializer with an async four-phase word handshake; ack after SYNC_STAGES+1 edges.
// Upstream is held off by withholding ack while the holding register is full; idle word fills empty slots.
module lvds_serializer #(
   parameter int                        PARALLEL_WIDTH = 8,
   parameter int                        SERIAL_RATIO   = 8,
   parameter int                        SYNC_STAGES    = 2,
   parameter logic [PARALLEL_WIDTH-1:0] IDLE_WORD      = 8'hF0
) (
   input  logic              clk_serial,
   input  logic              reset,
   lvds_serializer_if.slave  bus
);
   localparam int                CNT_W    = (SERIAL_RATIO > 1) ? $clog2(SERIAL_RATIO) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SERIAL_RATIO - 1);

   typedef enum logic {HS_IDLE, HS_ACK} hs_state_t;

   logic [SYNC_STAGES-1:0]    sync_q, sync_d;
   hs_state_t                 state_q, state_d;
   logic [PARALLEL_WIDTH-1:0] hold_reg_q, hold_reg_d;
   logic                      hold_full_q, hold_full_d;
   logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
   logic [PARALLEL_WIDTH-1:0] shift_reg_q, shift_reg_d;
   logic                      data_q, data_d;
   logic                      underrun_q, underrun_d;

   logic valid_s;
   logic capture;
   logic load;

   assign valid_s = sync_q[SYNC_STAGES-1];
   assign load    = (bit_cnt_q == CNT_LAST);

   // Capture only looks at the registered hold_full, so a load in the same cycle defers it by one.
   assign capture = (state_q == HS_IDLE) && valid_s && !hold_full_q;

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], bus.tx_word_valid};
      state_d     = state_q;
      hold_reg_d  = hold_reg_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q + CNT_W'(1);
      shift_reg_d = {shift_reg_q[PARALLEL_WIDTH-2:0], 1'b0};
      data_d      = data_q;
      underrun_d  = 1'b0;

      case (state_q)
         HS_IDLE: begin
            if (capture) begin
               state_d = HS_ACK;
            end
         end
         HS_ACK: begin
            if (!valid_s) begin
               state_d = HS_IDLE;
            end
         end
         default: state_d = HS_IDLE;
      endcase

      if (load) begin
         bit_cnt_d = '0;
         data_d    = hold_full_q;
         if (hold_full_q) begin
            shift_reg_d = hold_reg_q;
            hold_full_d = 1'b0;
         end else begin
            shift_reg_d = IDLE_WORD;
            underrun_d  = data_q;
         end
      end

      if (capture) begin
         hold_reg_d  = bus.tx_parallel_word;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk_serial) begin
      if (reset) begin
         sync_q      <= '0;
         state_q     <= HS_IDLE;
         hold_reg_q  <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         shift_reg_q <= IDLE_WORD;
         data_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         hold_reg_q  <= hold_reg_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_reg_q <= shift_reg_d;
         data_q      <= data_d;
         underrun_q  <= underrun_d;
      end
   end

   assign bus.ack_serial        = (state_q == HS_ACK);
   assign bus.serial_out        = shift_reg_q[PARALLEL_WIDTH-1];
   assign bus.serial_frame      = (bit_cnt_q == '0);
   assign bus.serial_data_valid = data_q;
   assign bus.underrun          = underrun_q;
endmodule

// File: tb/tb_lvds_serializer.sv
// Directed bench for lvds_serializer: cycle-indexed stimulus, per-cycle output log, hand-computed slot contents.
module tb_lvds_serializer;
   localparam int LOGN = 256;

   logic clk_serial;
   logic reset;
   int   t;
   int   n_assert;
   int   n_fail;
   logic [4:0] lg [0:LOGN-1];   // {ack, underrun, data_valid, frame, serial_out}

   lvds_serializer_if #(.PARALLEL_WIDTH(8)) bus ();

   lvds_serializer #(
      .PARALLEL_WIDTH(8),
      .SERIAL_RATIO  (8),
      .SYNC_STAGES   (2),
      .IDLE_WORD     (8'hF0)
   ) dut (
      .clk_serial(clk_serial),
      .reset     (reset),
      .bus       (bus)
   );

   initial clk_serial = 1'b0;
   always #5 clk_serial = ~clk_serial;

   initial begin
      #60000;
      $display("FAIL watchdog: simulation did not finish, t=%0d", t);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_serial);
      #1;
      t++;
      if (t >= 0 && t < LOGN)
         lg[t] = {bus.ack_serial, bus.underrun, bus.serial_data_valid, bus.serial_frame, bus.serial_out};
   endtask

   task automatic tick_to(input int n);
      while (t < n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic chk_slot(input string tag, input int t0, input logic [7:0] w, input logic dv);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_out%0d", tag, i), 32'(lg[t0+i][0]), 32'(w[7-i]));
         chk($sformatf("%s_dv%0d", tag, i), 32'(lg[t0+i][2]), 32'(dv));
         chk($sformatf("%s_frame%0d", tag, i), 32'(lg[t0+i][1]), 32'(i == 0));
      end
   endtask

   task automatic handshake(input logic [7:0] w);
      int n;
      bus.tx_parallel_word = w;
      bus.tx_word_valid    = 1'b1;
      n = 0;
      while (bus.ack_serial !== 1'b1 && n < 20) begin tick(); n++; end
      chk("hs_ack_rise", 32'(bus.ack_serial), 32'd1);
      bus.tx_word_valid = 1'b0;
      n = 0;
      while (bus.ack_serial !== 1'b0 && n < 20) begin tick(); n++; end
      chk("hs_ack_fall", 32'(bus.ack_serial), 32'd0);
   endtask

   initial begin
      logic [7:0] idle_w;
      int cnt;
      idle_w   = 8'hF0;
      n_assert = 0;
      n_fail   = 0;
      t        = -3;
      reset    = 1'b1;
      bus.tx_word_valid    = 1'b0;
      bus.tx_parallel_word = 8'h00;

      // Reset held for three edges
      tick(); tick(); tick();
      chk("rst_ack",      32'(bus.ack_serial),        32'd0);
      chk("rst_frame",    32'(bus.serial_frame),      32'd1);
      chk("rst_dv",       32'(bus.serial_data_valid), 32'd0);
      chk("rst_underrun", 32'(bus.underrun),          32'd0);
      chk("rst_out",      32'(bus.serial_out),        32'd1);
      reset = 1'b0;

      // Idle stream: F0 repeating, frame every 8th cycle
      for (int k = 0; k < 16; k++) begin
         tick_to(k);
         chk("idle_out",   32'(bus.serial_out),        32'(idle_w[7 - (k % 8)]));
         chk("idle_frame", 32'(bus.serial_frame),      32'(k % 8 == 0));
         chk("idle_dv",    32'(bus.serial_data_valid), 32'd0);
         chk("idle_ack",   32'(bus.ack_serial),        32'd0);
      end

      // Single word 3C
      tick_to(16);
      bus.tx_parallel_word = 8'h3C;
      bus.tx_word_valid    = 1'b1;
      tick_to(18); chk("single_ack_early", 32'(bus.ack_serial), 32'd0);
      tick_to(19); chk("single_ack_rise",  32'(bus.ack_serial), 32'd1);
      bus.tx_word_valid = 1'b0;
      tick_to(21); chk("single_ack_hold",  32'(bus.ack_serial), 32'd1);
      tick_to(22); chk("single_ack_fall",  32'(bus.ack_serial), 32'd0);
      tick_to(33);
      chk_slot("single", 24, 8'h3C, 1'b1);
      chk("single_no_underrun_pre", 32'(lg[31][3]), 32'd0);
      chk("single_underrun",        32'(lg[32][3]), 32'd1);
      chk("single_idle_dv",         32'(lg[32][2]), 32'd0);
      chk("single_underrun_pulse",  32'(lg[33][3]), 32'd0);

      // Back-to-back A5, 0F, FF
      tick_to(40);
      handshake(8'hA5);
      handshake(8'h0F);
      handshake(8'hFF);
      tick_to(80);
      chk_slot("b2b_a5", 48, 8'hA5, 1'b1);
      chk_slot("b2b_0f", 56, 8'h0F, 1'b1);
      chk_slot("b2b_ff", 64, 8'hFF, 1'b1);
      cnt = 0;
      for (int k = 48; k < 72; k++) cnt += int'(lg[k][3]);
      chk("b2b_no_underrun", 32'(cnt), 32'd0);
      chk("b2b_underrun_end", 32'(lg[72][3]), 32'd1);

      // Capture/load collision: new valid_s lands on the load cycle with 81 held
      tick_to(80);
      bus.tx_parallel_word = 8'h81;
      bus.tx_word_valid    = 1'b1;
      tick_to(83); chk("coll_ack_81", 32'(bus.ack_serial), 32'd1);
      bus.tx_word_valid = 1'b0;
      tick_to(85);
      bus.tx_parallel_word = 8'h42;
      bus.tx_word_valid    = 1'b1;
      tick_to(88); chk("coll_blocked", 32'(bus.ack_serial), 32'd0);
      tick_to(89); chk("coll_capture", 32'(bus.ack_serial), 32'd1);
      bus.tx_word_valid = 1'b0;
      tick_to(92); chk("coll_ack_fall", 32'(bus.ack_serial), 32'd0);
      tick_to(105);
      chk_slot("coll_81", 88, 8'h81, 1'b1);
      chk_slot("coll_42", 96, 8'h42, 1'b1);
      chk("coll_underrun", 32'(lg[104][3]), 32'd1);

      // Valid held high for 40 cycles: one capture only
      tick_to(112);
      bus.tx_parallel_word = 8'h55;
      bus.tx_word_valid    = 1'b1;
      tick_to(152);
      cnt = 0;
      for (int k = 112; k <= 152; k++) cnt += int'(lg[k][2]);
      chk("held_dv_bits", 32'(cnt), 32'd8);
      cnt = 0;
      for (int k = 115; k <= 152; k++) cnt += int'(lg[k][4]);
      chk("held_ack_high", 32'(cnt), 32'd38);
      chk("held_ack_pre", 32'(lg[114][4]), 32'd0);
      chk_slot("held_55", 120, 8'h55, 1'b1);
      chk("held_underrun", 32'(lg[128][3]), 32'd1);
      bus.tx_word_valid = 1'b0;
      tick_to(155); chk("held_ack_fall", 32'(bus.ack_serial), 32'd0);

      // Reset mid-word with C3 on the wire and 99 held
      tick_to(160);
      handshake(8'hC3);
      handshake(8'h99);
      tick_to(172);
      chk("mid_dv_before", 32'(bus.serial_data_valid), 32'd1);
      chk("mid_out_before", 32'(bus.serial_out), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_post_dv",    32'(bus.serial_data_valid), 32'd0);
      chk("mid_post_frame", 32'(bus.serial_frame),      32'd1);
      chk("mid_post_out",   32'(bus.serial_out),        32'd1);
      tick_to(200);
      cnt = 0;
      for (int k = 173; k <= 200; k++) cnt += int'(lg[k][2]) + int'(lg[k][3]);
      chk("mid_held_discarded", 32'(cnt), 32'd0);
      chk_slot("mid_idle", 181, 8'hF0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/lvds_serializer.md
# lvds_serializer

Serial-domain stage directly downstream of the system-domain LVDS transmit front end. Accepts parallel words from the system clock domain over a four-phase valid/ack handshake, with the incoming valid synchronized inside the block. Shifts each word out MSB-first, one bit per `clk_serial` cycle. Double-buffered: a holding register backs a shift register so back-to-back words stream with no gap bits; when no word is pending, a fixed idle word is transmitted instead.

## Interface
- `PARALLEL_WIDTH`, 8: word width in bits.
- `SERIAL_RATIO`, 8: bits shifted per word; must equal `PARALLEL_WIDTH`.
- `SYNC_STAGES`, 2: flops in the `tx_word_valid` synchronizer; minimum 2.
- `IDLE_WORD`, 8'hF0: word sent when no data is pending; `PARALLEL_WIDTH` bits.

- `clk_serial` in 1: serial-domain clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `tx_parallel_word` in `PARALLEL_WIDTH`: word from the system domain; stable while `tx_word_valid` is high.
- `tx_word_valid` in 1: request from the system domain; asynchronous to `clk_serial`.
- `ack_serial` out 1: four-phase acknowledge back to the system domain.
- `serial_out` out 1: serial bit; equals shift-register MSB.
- `serial_frame` out 1: high on the first (MSB) bit of every word slot.
- `serial_data_valid` out 1: high for every bit of a data word; low for idle words.
- `underrun` out 1: one-cycle pulse when an idle word follows a data word.

## Operation
- Synchronizer: `valid_s` is `tx_word_valid` passed through `SYNC_STAGES` flops. `tx_parallel_word` is sampled unsynchronized; it is stable by protocol.
- Handshake FSM, states `HS_IDLE` and `HS_ACK`:
  - In `HS_IDLE`, when `valid_s`=1 and `hold_full`=0: capture the word into `hold_reg`, set `hold_full`=1, set `ack_serial`=1, go to `HS_ACK`.
  - In `HS_IDLE`, when `valid_s`=1 and `hold_full`=1: wait in `HS_IDLE`.
  - In `HS_ACK`, when `valid_s`=0: clear `ack_serial`, go to `HS_IDLE`.
  - The upstream stage must drop valid between words. A valid held high after ack causes no recapture.
- Serializer:
  - `bit_cnt` counts 0..`SERIAL_RATIO`-1 and wraps.
  - When `bit_cnt`≠`SERIAL_RATIO`-1: `shift_reg` shifts left by one.
  - When `bit_cnt`=`SERIAL_RATIO`-1 (last bit of the slot): load the next word.
    - If `hold_full`=1: load `hold_reg`, clear `hold_full`, set the data flag to 1.
    - If `hold_full`=0: load `IDLE_WORD`, set the data flag to 0.
- Simultaneous capture and load in one cycle: the load takes the old `hold_reg` contents and clears `hold_full`. Capture is blocked that cycle because `hold_full` was still 1. Capture happens at the earliest on the next cycle.
- `underrun` pulses on the load cycle's successor (the first bit of the idle slot) when the outgoing slot was data and the incoming slot is idle.
- Output derivation:
  - `serial_frame` = (`bit_cnt`==0).
  - `serial_data_valid` = data flag.
  - `serial_out` = `shift_reg[MSB]`.
  - All are register-derived; there is no combinational path from inputs.

## Timing
- Reset (synchronous, takes effect on the next `clk_serial` edge):
  - Registers: `bit_cnt`=0, `shift_reg`=`IDLE_WORD`, data flag=0, `hold_full`=0, synchronizer flops=0, FSM=`HS_IDLE`.
  - Outputs: `ack_serial`=0, `serial_frame`=1, `serial_data_valid`=0, `underrun`=0, `serial_out`=`IDLE_WORD[MSB]` (1 for the default).
- Reset mid-word drops the current word and any held word. The next slot starts at `bit_cnt`=0 with the idle word.
- Request to ack: `tx_word_valid` rises before edge E. Then `valid_s`=1 after edge E+`SYNC_STAGES`-1, and `ack_serial`=1 after edge E+`SYNC_STAGES` (default: 2 edges of sync plus 1 capture).
- Ack release: `ack_serial` falls `SYNC_STAGES`+1 edges after `tx_word_valid` falls.
- Capture to wire: first data bit appears at the next slot boundary. This is 1..`SERIAL_RATIO` cycles after capture.
- Throughput: one word per `SERIAL_RATIO` cycles, provided each handshake round trip fits within one slot.
- Slot length is fixed at `SERIAL_RATIO` cycles. `serial_frame` is periodic regardless of data.

## Test plan
- Reset idle: hold `reset` for 3 cycles, then release with `tx_word_valid`=0. Required: `serial_out` repeats 1,1,1,1,0,0,0,0; `serial_frame` is high every 8th cycle; `serial_data_valid`=0; `ack_serial`=0.
- Single word: assert valid with word 8'h3C, drop valid after ack. Required:
  - `ack_serial` rises 3 cycles after valid.
  - Next slot emits 0,0,1,1,1,1,0,0 with `serial_data_valid`=1.
  - Following slot is idle, with `underrun`=1 on its first bit.
  - `ack_serial` falls 3 cycles after valid drops.
- Back-to-back: handshake 8'hA5, 8'h0F and 8'hFF fast enough. Required: 24 contiguous data bits 10100101 00001111 11111111, no idle slot between them, and no `underrun` until after the last word.
- Capture/load collision: `valid_s` rises on the cycle `bit_cnt`=7 while `hold_full`=1 with 8'h81. Required: 8'h81 loads, and the new word is captured on the next cycle and sent in the following slot.
- Valid held high: `tx_word_valid` stays at 1 for 40 cycles with word 8'h55. Required: exactly one 8'h55 data slot and `ack_serial` stays 1.
- Reset mid-word: assert `reset` when `bit_cnt`=4 during data word 8'hC3. Required: `serial_data_valid`=0 and `serial_frame`=1 on the first post-reset cycle, and the held word is discarded.
